// File: rtl/store_merge_rmw.sv
// ============================================================================
// Module      : store_merge_rmw
// Description : Turns sb/sh/sw stores into word-only memory writes. Sub-word
//               stores are done as read-modify-write.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module store_merge_rmw #(
  parameter int N_Bits = 32,
  parameter int A_Bits = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_req,
  input  logic [A_Bits-1:0] st_addr,
  input  logic [N_Bits-1:0] st_data,
  input  logic [2:0]        st_type,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_misalign,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [A_Bits-1:0] mem_addr,
  output logic [N_Bits-1:0] mem_wdata,
  input  logic [N_Bits-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [1:0] K_WORD = 2'd0;
  localparam logic [1:0] K_BYTE = 2'd1;
  localparam logic [1:0] K_HALF = 2'd2;

  state_t            state;
  logic [A_Bits-1:0] addr_q;
  logic [N_Bits-1:0] wdata_q;
  logic [1:0]        kind_q;

  logic [1:0]        kind;
  logic              misalign;
  logic [N_Bits-1:0] merged;

  always_comb begin
    kind = K_WORD;
    case (st_type)
      3'b010, 3'b100: kind = K_BYTE;
      3'b001, 3'b011: kind = K_HALF;
      default:        kind = K_WORD;
    endcase
    misalign = ((kind == K_HALF) && st_addr[0]) ||
               ((kind == K_WORD) && (st_addr[1:0] != 2'b00));
  end

  // Splice the captured low bits of the store data into the lane read back.
  always_comb begin
    merged = mem_rdata;
    if (kind_q == K_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (kind_q == K_HALF) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  assign st_busy   = (state == READ) || (state == WRITE) ||
                     ((state == IDLE) && st_req && !misalign);
  assign mem_addr  = ((state == READ) || (state == WRITE)) ?
                     {addr_q[A_Bits-1:2], 2'b00} : '0;
  assign mem_wdata = (state == WRITE) ? wdata_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      kind_q      <= K_WORD;
      st_done     <= 1'b0;
      st_misalign <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
    end else begin
      st_done     <= 1'b0;
      st_misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (st_req) begin
            addr_q  <= st_addr;
            wdata_q <= st_data;
            kind_q  <= kind;
            if (misalign) begin
              st_misalign <= 1'b1;
              state       <= ERR;
            end else if (kind == K_WORD) begin
              mem_wr_req <= 1'b1;
              state      <= WRITE;
            end else begin
              mem_rd_req <= 1'b1;
              state      <= READ;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            wdata_q    <= merged;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_wr_req <= 1'b0;
            st_done    <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_merge_rmw.sv
// ============================================================================
// Module      : tb_store_merge_rmw
// Description : Self-checking bench for store_merge_rmw with a behavioural
//               word memory and a lane-arithmetic reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_store_merge_rmw;

  logic        clk = 1'b0;
  logic        reset, st_req;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_type;
  logic        st_busy, st_done, st_misalign, mem_rd_req, mem_wr_req;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack = 1'b0;

  store_merge_rmw #(.N_Bits(32), .A_Bits(32)) dut (
    .clk(clk), .reset(reset), .st_req(st_req), .st_addr(st_addr),
    .st_data(st_data), .st_type(st_type), .st_busy(st_busy),
    .st_done(st_done), .st_misalign(st_misalign), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ack_delay = 0, wait_cnt = 0;
  bit stray_en = 0;
  int proto_err = 0, rd_cnt = 0, done_cnt = 0, mis_cnt = 0, exp_mis_total = 0;
  bit [31:0] last_rd_addr;
  bit [31:0] mem [bit [31:0]];
  typedef struct { bit [31:0] a; bit [31:0] d; } wr_t;
  wr_t wr_q[$];
  bit pend_rd, pend_wr, pend_rst;
  bit [31:0] pend_addr, pend_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] rd_word(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  // Reference model: 0 = word, 1 = byte, 2 = half
  function automatic int kind_of(input bit [2:0] t);
    if (t == 3'd2 || t == 3'd4) return 1;
    if (t == 3'd1 || t == 3'd3) return 2;
    return 0;
  endfunction

  function automatic bit model_mis(input bit [31:0] a, input bit [2:0] t);
    int off = int'(a % 32'd4);
    if (kind_of(t) == 2) return (off % 2) != 0;
    if (kind_of(t) == 0) return off != 0;
    return 1'b0;
  endfunction

  function automatic bit [31:0] model_merge(input bit [31:0] old, input bit [31:0] a,
                                            input bit [31:0] d, input bit [2:0] t);
    int off = int'(a % 32'd4);
    int sh;
    bit [31:0] mask;
    if (kind_of(t) == 0) return d;
    if (kind_of(t) == 1) begin
      sh = 8 * off;
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * (off / 2);
      mask = 32'hFFFF << sh;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  // Memory responder: acks after ack_delay waiting cycles, logs committed traffic
  always @(negedge clk) begin
    if (mem_rd_req === 1'b1 && mem_wr_req === 1'b1) proto_err++;
    if ((pend_rd || pend_wr) && !pend_rst) begin
      if ((pend_rd && mem_rd_req !== 1'b1) || (pend_wr && mem_wr_req !== 1'b1) ||
          mem_addr !== pend_addr || (pend_wr && mem_wdata !== pend_wdata))
        proto_err++;
    end
    if (mem_ack) wait_cnt = 0;
    mem_ack = 1'b0;
    if (mem_rd_req === 1'b1 || mem_wr_req === 1'b1) begin
      mem_rdata = (mem_rd_req === 1'b1) ? rd_word(mem_addr) : $urandom;
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (!reset) begin
          if (mem_wr_req === 1'b1) begin
            wr_q.push_back('{mem_addr, mem_wdata});
            mem[mem_addr] = mem_wdata;
          end
          if (mem_rd_req === 1'b1) begin
            rd_cnt++;
            last_rd_addr = mem_addr;
          end
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt  = 0;
      mem_rdata = $urandom;
      mem_ack   = stray_en && ($urandom_range(0, 3) == 0);
    end
    pend_rd    = (mem_rd_req === 1'b1) && !mem_ack;
    pend_wr    = (mem_wr_req === 1'b1) && !mem_ack;
    pend_addr  = mem_addr;
    pend_wdata = mem_wdata;
    pend_rst   = reset;
    if (st_done === 1'b1) done_cnt++;
    if (st_misalign === 1'b1) mis_cnt++;
  end

  task automatic do_store(input bit [31:0] a, input bit [31:0] d, input bit [2:0] t,
                          input int dly, output int lat, output int busy_n,
                          output bit got_done, output bit got_mis);
    ack_delay = dly;
    st_addr = a; st_data = d; st_type = t; st_req = 1'b1;
    lat = 0; busy_n = 0; got_done = 0; got_mis = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (st_busy === 1'b1) busy_n++;
      if (st_done === 1'b1) got_done = 1;
      if (st_misalign === 1'b1) got_mis = 1;
      if (got_done || got_mis) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
      st_req = 1'b0;
    end
    @(posedge clk); #1;
    st_req = 1'b0;
  endtask

  task automatic verify(input string tag, input bit [31:0] a, input bit [31:0] d,
                        input bit [2:0] t, input int dly, input bit exp_mis,
                        input bit [31:0] exp_w, input int exp_lat);
    int lat, busy_n, nw0, nr0;
    bit gd, gm, rmw;
    rmw = !exp_mis && (kind_of(t) != 0);
    nw0 = wr_q.size();
    nr0 = rd_cnt;
    if (exp_mis) exp_mis_total++;
    do_store(a, d, t, dly, lat, busy_n, gd, gm);
    chk({tag, ".done"}, 32'(gd), 32'(!exp_mis));
    chk({tag, ".misalign"}, 32'(gm), 32'(exp_mis));
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".busy_cycles"}, busy_n, exp_mis ? 0 : exp_lat - 1);
    chk({tag, ".writes"}, wr_q.size(), nw0 + (exp_mis ? 0 : 1));
    if (!exp_mis && wr_q.size() > nw0) begin
      chk({tag, ".wr_addr"}, wr_q[nw0].a, a & ~32'h3);
      chk({tag, ".wr_data"}, wr_q[nw0].d, exp_w);
    end
    chk({tag, ".reads"}, rd_cnt, nr0 + (rmw ? 1 : 0));
    if (rmw && rd_cnt > nr0) chk({tag, ".rd_addr"}, last_rd_addr, a & ~32'h3);
  endtask

  typedef struct {
    bit [31:0] a; bit [31:0] d; bit [2:0] t; bit [31:0] init;
    int dly; bit mis; bit [31:0] w; int lat;
  } vec_t;
  vec_t vt[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nw0, d0;
    bit found;
    bit [8:0] dmask, bmask;
    bit [31:0] a, d, old;
    bit [2:0] t;
    int dly, lat;
    bit mis;

    vt[0] = '{32'h100, 32'hDEADBEEF, 3'b000, 32'h0,        0, 1'b0, 32'hDEADBEEF, 3};
    vt[1] = '{32'h203, 32'h000000AB, 3'b010, 32'h11223344, 0, 1'b0, 32'hAB223344, 4};
    vt[2] = '{32'h302, 32'h0000CAFE, 3'b001, 32'h11223344, 3, 1'b0, 32'hCAFE3344, 10};
    vt[3] = '{32'h401, 32'h00001234, 3'b001, 32'h0,        0, 1'b1, 32'h0,        2};
    vt[4] = '{32'h402, 32'h00005555, 3'b000, 32'h0,        0, 1'b1, 32'h0,        2};
    vt[5] = '{32'h111, 32'hFFFFFF5A, 3'b100, 32'hA0B0C0D0, 1, 1'b0, 32'hA0B05AD0, 6};
    vt[6] = '{32'h120, 32'hFFFF1357, 3'b011, 32'hAAAABBBB, 0, 1'b0, 32'hAAAA1357, 4};
    vt[7] = '{32'h12C, 32'h0BADF00D, 3'b111, 32'h0,        2, 1'b0, 32'h0BADF00D, 5};
    vt[8] = '{32'h131, 32'h00000077, 3'b101, 32'h0,        0, 1'b1, 32'h0,        2};
    vt[9] = '{32'h140, 32'h600DCAFE, 3'b110, 32'h0,        0, 1'b0, 32'h600DCAFE, 3};

    reset = 1'b1; st_req = 1'b0; st_addr = '0; st_data = '0; st_type = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", st_busy, 0);
    chk("reset.done", st_done, 0);
    chk("reset.misalign", st_misalign, 0);
    chk("reset.rd_req", mem_rd_req, 0);
    chk("reset.wr_req", mem_wr_req, 0);
    chk("reset.addr", mem_addr, 0);
    chk("reset.wdata", mem_wdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    stray_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      mem[vt[i].a & ~32'h3] = vt[i].init;
      verify($sformatf("vec%0d", i), vt[i].a, vt[i].d, vt[i].t, vt[i].dly,
             vt[i].mis, vt[i].w, vt[i].lat);
    end

    for (int i = 0; i < 150; i++) begin
      a   = 32'h800 + 32'($urandom_range(0, 255));
      d   = $urandom;
      t   = 3'($urandom_range(0, 7));
      dly = $urandom_range(0, 2);
      mis = model_mis(a, t);
      old = rd_word(a & ~32'h3);
      lat = mis ? 2 : ((kind_of(t) == 0) ? 3 + dly : 4 + 2 * dly);
      verify($sformatf("rnd%0d", i), a, d, t, dly, mis, model_merge(old, a, d, t), lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Reset while a write is waiting for its ack
    mem[32'h600] = 32'h01020304;
    ack_delay = 5;
    st_addr = 32'h601; st_data = 32'h77; st_type = 3'b010; st_req = 1'b1;
    @(posedge clk); #1;
    st_req = 1'b0;
    found = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (mem_wr_req === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("rst.reached_write", 32'(found), 1);
    nw0 = wr_q.size();
    d0  = done_cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst.wr_req", mem_wr_req, 0);
    chk("rst.rd_req", mem_rd_req, 0);
    chk("rst.busy", st_busy, 0);
    chk("rst.addr", mem_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("rst.no_write", wr_q.size(), nw0);
    chk("rst.no_done", done_cnt, d0);
    mem[32'h500] = 32'h99887766;
    verify("after_rst", 32'h500, 32'h000000C3, 3'b010, 0, 1'b0, 32'h998877C3, 4);

    // Back-to-back word stores with st_req held high
    ack_delay = 0;
    st_addr = 32'h700; st_data = 32'h11111111; st_type = 3'b000; st_req = 1'b1;
    nw0 = wr_q.size();
    dmask = '0; bmask = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (st_done === 1'b1) dmask[n] = 1'b1;
      if (st_busy === 1'b1) bmask[n] = 1'b1;
      @(posedge clk); #1;
      if (n == 3) st_data = 32'h22222222;
      if (n == 6) st_req = 1'b0;
    end
    chk("b2b.done_cycles", 32'(dmask), 32'h048);
    chk("b2b.busy_cycles", 32'(bmask), 32'h036);
    chk("b2b.writes", wr_q.size(), nw0 + 2);
    if (wr_q.size() >= nw0 + 2) begin
      chk("b2b.wr0", wr_q[nw0].d, 32'h11111111);
      chk("b2b.wr1", wr_q[nw0 + 1].d, 32'h22222222);
      chk("b2b.addr1", wr_q[nw0 + 1].a, 32'h700);
    end

    chk("protocol_errors", proto_err, 0);
    chk("misalign_pulses", mis_cnt, exp_mis_total);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_merge_rmw.md
Name: store_merge_rmw

Overview:
- Store-side counterpart of the load extender: takes sw/sh/sb requests from the core and writes them to a word-only data memory/cache port that has no byte enables.
- Word stores go straight to a single write.
- Byte/half stores use read-modify-write: read the word, splice the byte/half into the addressed lane, write the word back.
- Sits between the core's MEM stage and the cache. Stalls the core via st_busy until the store completes.

Parameters:
- N_Bits, 32, data word width; lane math is defined for 32 only.
- A_Bits, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- st_req  in  1  store request from MEM stage
- st_addr  in  A_Bits  byte address
- st_data  in  N_Bits  store data (rs2); byte/half taken from low bits
- st_type  in  3  010/100 byte, 001/011 half, else word (same encoding as Loadtype)
- st_busy  out  1  stall to core
- st_done  out  1  one-cycle pulse, store committed
- st_misalign  out  1  one-cycle pulse, store rejected
- mem_rd_req  out  1  word read request
- mem_wr_req  out  1  word write request
- mem_addr  out  A_Bits  word-aligned address {addr[A_Bits-1:2],2'b00}
- mem_wdata  out  N_Bits  merged write word
- mem_rdata  in  N_Bits  read data, valid on mem_rd_req & mem_ack
- mem_ack  in  1  completes the current rd/wr request

Behaviour:
- States: IDLE, READ, WRITE, DONE, ERR.
- Reset: state=IDLE; all outputs 0; captured addr/data/type registers = 0. Reset mid-operation abandons the store, and requests drop at that edge. No write is issued after reset.
- Accept: st_req=1 in IDLE captures st_addr, st_data and the decoded type. st_req is ignored in all other states.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. IDLE -> ERR on a misaligned request. No memory access is made.
- Byte or aligned half: IDLE -> READ. Aligned word: IDLE -> WRITE with mem_wdata=st_data.
- READ: mem_rd_req=1, held until mem_ack. On the ack cycle, capture mem_rdata, merge, then -> WRITE.
- WRITE: mem_wr_req=1, mem_wdata=merged word, held stable until mem_ack. Then -> DONE.
- mem_ack is allowed in the same cycle the request first rises (zero-wait). mem_ack with no request pending is ignored.
- Merge, byte: lane k=addr[1:0], bits[8k+7:8k]=st_data[7:0]; all other bits from mem_rdata.
- Merge, half: h=addr[1], bits[16h+15:16h]=st_data[15:0]; the rest from mem_rdata.
- mem_addr is held constant from accept through the end of WRITE. It is 0 in IDLE.
- DONE: st_done=1 for exactly one cycle, st_busy=0, -> IDLE.
- ERR: st_misalign=1 for exactly one cycle, st_busy=0, -> IDLE.
- st_busy = (state is READ or WRITE) | (state==IDLE & st_req & aligned). This is combinational, so the core stalls on the accept cycle.
- mem_rd_req and mem_wr_req are never high together.
- Latency with zero-wait memory: word store = 3 cycles, accept to st_done. Byte/half store = 4 cycles.
- A new st_req is not accepted in DONE or ERR; the earliest accept is the following IDLE cycle.

Test Plan:
- Word store: addr 0x100, data 0xDEADBEEF, type 000, ack same cycle -> no mem_rd_req; one write of 0xDEADBEEF to 0x100; st_done on the 3rd cycle.
- Byte store: addr 0x203, data 0x000000AB, type 010, mem_rdata 0x11223344 -> read from 0x200, write 0xAB223344, st_done pulse.
- Half store: addr 0x302, data 0x0000CAFE, type 001, mem_rdata 0x11223344, 3-cycle ack delay on both read and write -> write 0xCAFE3344; requests held steady while waiting; st_busy high throughout.
- Misaligned: half at 0x401, then word at 0x402 -> st_misalign pulses, no mem requests, st_busy low.
- Reset asserted during the WRITE wait -> next cycle IDLE, mem_wr_req=0, no st_done. A subsequent byte store at 0x500 completes normally.
- Back-to-back stores with st_req held continuously -> the second request is accepted only after DONE; exactly one write per store.
